// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the main-memory fill scheduler.
// Block geometry is derived from WORDS_PER_BLK and the memory word width.
package mem_ctrl_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int WORDS_PER_BLK = 8;
    localparam int OFF_W         = $clog2(WORDS_PER_BLK);
    localparam int BYTE_W        = $clog2(DATA_W / 8);
    localparam int BLK_W         = OFF_W + BYTE_W;

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DRAIN} sched_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OFF_W-1:0]  off_t;

    function automatic addr_t blk_base(input addr_t a);
        return a & ~addr_t'((1 << BLK_W) - 1);
    endfunction

    function automatic addr_t word_addr(input addr_t base, input off_t off);
        return base | (addr_t'(off) << BYTE_W);
    endfunction

    function automatic off_t word_off(input addr_t a);
        return a[BLK_W-1:BYTE_W];
    endfunction

endpackage

// File: rtl/mem_fill_sched_if.sv
// Shared main-memory port: the scheduler drives it as master, the memory
// model answers as slave.
interface mem_fill_sched_if;

    logic                 mem_enable;
    logic                 mem_wr;
    mem_ctrl_pkg::addr_t  mem_addr;
    mem_ctrl_pkg::data_t  mem_wdata;
    logic                 mem_data_valid;
    mem_ctrl_pkg::data_t  mem_rdata;

    modport master (
        output mem_enable, mem_wr, mem_addr, mem_wdata,
        input  mem_data_valid, mem_rdata
    );

    modport slave (
        input  mem_enable, mem_wr, mem_addr, mem_wdata,
        output mem_data_valid, mem_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the I-cache and D-cache miss paths.
// The pointer only moves when a fill is taken while both sides were asking.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_icache_i,
    input  logic   req_dcache_i,
    input  logic   take_i,
    output logic   valid_o,
    output owner_t win_o
);

    owner_t ptr_q;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        valid_o = req_icache_i | req_dcache_i;
        win_o   = OWN_I;
        if (req_icache_i && req_dcache_i) begin
            win_o = ptr_q;
        end else if (req_dcache_i) begin
            win_o = OWN_D;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= OWN_I;
        end else if (take_i && req_icache_i && req_dcache_i) begin
            ptr_q <= (win_o == OWN_I) ? OWN_D : OWN_I;
        end
    end

endmodule

// File: rtl/mem_fill_sched.sv
// Main-memory port scheduler: write-through stores, then round-robin block fills.
// Define CRITICAL_WORD_FIRST_EN to start each fill at the missing word.
module mem_fill_sched
    import mem_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_miss,
    input  addr_t  i_miss_addr,
    input  logic   d_miss,
    input  addr_t  d_miss_addr,
    input  logic   d_wr_req,
    input  addr_t  d_wr_addr,
    input  data_t  d_wr_data,
    mem_fill_sched_if.master mem,
    output data_t  fill_data,
    output off_t   fill_word_idx,
    output logic   i_fill_we,
    output logic   d_fill_we,
    output logic   i_fill_done,
    output logic   d_fill_done,
    output logic   d_wr_done,
    output logic   busy
);

    sched_state_t state_q;
    owner_t       owner_q;
    addr_t        base_q;
    off_t         start_off_q;
    off_t         issue_cnt_q;
    off_t         recv_cnt_q;
    logic         mem_enable_q;
    logic         mem_wr_q;
    addr_t        mem_addr_q;
    data_t        mem_wdata_q;
    logic         i_done_q;
    logic         d_done_q;
    logic         wr_done_q;

    logic         arb_valid;
    owner_t       arb_win;
    logic         done_any;
    logic         take_fill;
    logic         accept;
    logic         last_ret;
    addr_t        miss_addr;
    addr_t        grant_base;
    off_t         grant_off;

    rr_arb2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_icache_i (i_miss),
        .req_dcache_i (d_miss),
        .take_i       (take_fill),
        .valid_o      (arb_valid),
        .win_o        (arb_win)
    );

    // A done pulse blocks the grant so a still-asserted request is not served twice.
    always_comb begin
        done_any   = i_done_q | d_done_q | wr_done_q;
        take_fill  = (state_q == IDLE) && !done_any && !d_wr_req && arb_valid;
        miss_addr  = (arb_win == OWN_D) ? d_miss_addr : i_miss_addr;
        grant_base = blk_base(miss_addr);
`ifdef CRITICAL_WORD_FIRST_EN
        grant_off  = word_off(miss_addr);
`else
        grant_off  = '0;
`endif
        accept     = mem.mem_data_valid && ((state_q == FILL) || (state_q == DRAIN));
        last_ret   = accept && (recv_cnt_q == off_t'(WORDS_PER_BLK - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            base_q       <= '0;
            start_off_q  <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            wr_done_q    <= 1'b0;
        end else begin
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!done_any && d_wr_req) begin
                        state_q      <= WRITE;
                        mem_enable_q <= 1'b1;
                        mem_wr_q     <= 1'b1;
                        mem_addr_q   <= d_wr_addr;
                        mem_wdata_q  <= d_wr_data;
                    end else if (take_fill) begin
                        state_q      <= FILL;
                        owner_q      <= arb_win;
                        base_q       <= grant_base;
                        start_off_q  <= grant_off;
                        issue_cnt_q  <= '0;
                        recv_cnt_q   <= '0;
                        mem_enable_q <= 1'b1;
                        mem_wr_q     <= 1'b0;
                        mem_addr_q   <= word_addr(grant_base, grant_off);
                    end
                end
                WRITE: begin
                    state_q      <= IDLE;
                    mem_enable_q <= 1'b0;
                    mem_wr_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    wr_done_q    <= 1'b1;
                end
                FILL: begin
                    if (issue_cnt_q == off_t'(WORDS_PER_BLK - 1)) begin
                        state_q      <= DRAIN;
                        mem_enable_q <= 1'b0;
                        mem_addr_q   <= '0;
                    end else begin
                        issue_cnt_q <= issue_cnt_q + off_t'(1);
                        mem_addr_q  <= word_addr(base_q, start_off_q + issue_cnt_q + off_t'(1));
                    end
                end
                DRAIN: ;
                default: state_q <= IDLE;
            endcase

            // Returns arrive in issue order, so a counter is enough to place each word.
            if (accept) begin
                recv_cnt_q <= recv_cnt_q + off_t'(1);
                if (last_ret) begin
                    state_q      <= IDLE;
                    recv_cnt_q   <= '0;
                    start_off_q  <= '0;
                    issue_cnt_q  <= '0;
                    mem_enable_q <= 1'b0;
                    mem_addr_q   <= '0;
                    if (owner_q == OWN_I) begin
                        i_done_q <= 1'b1;
                    end else begin
                        d_done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign mem.mem_enable = mem_enable_q;
    assign mem.mem_wr     = mem_wr_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;

    assign fill_data     = mem.mem_rdata;
    assign fill_word_idx = start_off_q + recv_cnt_q;
    assign i_fill_we     = accept && (owner_q == OWN_I);
    assign d_fill_we     = accept && (owner_q == OWN_D);
    assign i_fill_done   = i_done_q;
    assign d_fill_done   = d_done_q;
    assign d_wr_done     = wr_done_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_fill_sched.sv
// Randomised bench for mem_fill_sched with a fixed-latency memory model and a
// transaction-level reference of the grant order and per-cycle bus activity.
module tb_mem_fill_sched;
    import mem_ctrl_pkg::*;

    localparam int MEM_LAT = 4;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   i_miss = 1'b0;
    logic   d_miss = 1'b0;
    logic   d_wr_req = 1'b0;
    addr_t  i_miss_addr = '0;
    addr_t  d_miss_addr = '0;
    addr_t  d_wr_addr = '0;
    data_t  d_wr_data = '0;
    data_t  fill_data;
    off_t   fill_word_idx;
    logic   i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy;

    mem_fill_sched_if mem_bus ();

    mem_fill_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_miss        (i_miss),
        .i_miss_addr   (i_miss_addr),
        .d_miss        (d_miss),
        .d_miss_addr   (d_miss_addr),
        .d_wr_req      (d_wr_req),
        .d_wr_addr     (d_wr_addr),
        .d_wr_data     (d_wr_data),
        .mem           (mem_bus),
        .fill_data     (fill_data),
        .fill_word_idx (fill_word_idx),
        .i_fill_we     (i_fill_we),
        .d_fill_we     (d_fill_we),
        .i_fill_done   (i_fill_done),
        .d_fill_done   (d_fill_done),
        .d_wr_done     (d_wr_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    typedef struct {
        addr_t addr;
        int    due;
    } rd_t;

    rd_t  rd_q[$];
    int   cyc = 0;
    logic spur = 1'b0;

    function automatic data_t mem_word(input addr_t a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_bus.mem_data_valid = spur;
        mem_bus.mem_rdata      = '0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            mem_bus.mem_data_valid = 1'b1;
            mem_bus.mem_rdata      = mem_word(rd_q[0].addr);
            void'(rd_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (mem_bus.mem_enable && !mem_bus.mem_wr) begin
            rd_q.push_back('{addr: mem_bus.mem_addr, due: cyc + MEM_LAT});
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string p);
        check({p, "_en"},    mem_bus.mem_enable, 0);
        check({p, "_wr"},    mem_bus.mem_wr, 0);
        check({p, "_addr"},  mem_bus.mem_addr, 0);
        check({p, "_wdata"}, mem_bus.mem_wdata, 0);
        check({p, "_iwe"},   i_fill_we, 0);
        check({p, "_dwe"},   d_fill_we, 0);
        check({p, "_idone"}, i_fill_done, 0);
        check({p, "_ddone"}, d_fill_done, 0);
        check({p, "_wdone"}, d_wr_done, 0);
        check({p, "_busy"},  busy, 0);
        check({p, "_idx"},   fill_word_idx, 0);
    endtask

    // ---------------- reference model ----------------
    owner_t rr_next  = OWN_I;
    logic   i_pend   = 1'b0;
    logic   d_pend   = 1'b0;
    logic   w_pend   = 1'b0;
    int     inject_c = -1;
    int     drop_c   = -1;
    addr_t  inj_addr = '0;
    data_t  inj_data = '0;

    // Called in the decision cycle; returns in the cycle after the done pulse.
    task automatic exec_fill(input owner_t own, input addr_t a);
        addr_t base;
        int    so;
        int    r;
        int    ix;
        logic  own_we, oth_we, own_dn, oth_dn;
        base = a & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
        so = int'(a[3:1]);
`else
        so = 0;
`endif
        sample();
        check("fill_dec_busy", busy, 0);
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c == inject_c) begin
                d_wr_req  = 1'b1;
                d_wr_addr = inj_addr;
                d_wr_data = inj_data;
                w_pend    = 1'b1;
                inject_c  = -1;
            end
            if (c == drop_c) begin
                if (own == OWN_I) i_miss = 1'b0;
                else d_miss = 1'b0;
            end
            sample();
            own_we = (own == OWN_I) ? i_fill_we   : d_fill_we;
            oth_we = (own == OWN_I) ? d_fill_we   : i_fill_we;
            own_dn = (own == OWN_I) ? i_fill_done : d_fill_done;
            oth_dn = (own == OWN_I) ? d_fill_done : i_fill_done;
            check($sformatf("fill_en c%0d", c), mem_bus.mem_enable, (c <= 8));
            if (c <= 8) begin
                check($sformatf("fill_addr c%0d", c), mem_bus.mem_addr,
                      base + addr_t'(2 * ((so + c - 1) % WORDS_PER_BLK)));
                check($sformatf("fill_wr c%0d", c), mem_bus.mem_wr, 0);
            end
            r = c - 1 - MEM_LAT;
            if (r >= 0 && r < WORDS_PER_BLK) begin
                ix = (so + r) % WORDS_PER_BLK;
                check($sformatf("fill_we c%0d", c), own_we, 1);
                check($sformatf("fill_idx c%0d", c), fill_word_idx, ix);
                check($sformatf("fill_data c%0d", c), fill_data, mem_word(base + addr_t'(2 * ix)));
            end else begin
                check($sformatf("fill_we_idle c%0d", c), own_we, 0);
            end
            check($sformatf("fill_other_we c%0d", c), oth_we, 0);
            check($sformatf("fill_done c%0d", c), own_dn, (c == 13));
            check($sformatf("fill_other_done c%0d", c), oth_dn, 0);
            check($sformatf("fill_wdone c%0d", c), d_wr_done, 0);
            check($sformatf("fill_busy c%0d", c), busy, (c <= 12));
        end
        step();
        if (own == OWN_I) begin
            i_miss = 1'b0;
            i_pend = 1'b0;
        end else begin
            d_miss = 1'b0;
            d_pend = 1'b0;
        end
    endtask

    task automatic exec_write(input addr_t a, input data_t dat);
        sample();
        check("wr_dec_busy", busy, 0);
        step();
        sample();
        check("wr_en", mem_bus.mem_enable, 1);
        check("wr_wr", mem_bus.mem_wr, 1);
        check("wr_addr", mem_bus.mem_addr, a);
        check("wr_wdata", mem_bus.mem_wdata, dat);
        check("wr_done_early", d_wr_done, 0);
        step();
        sample();
        check("wr_done", d_wr_done, 1);
        check("wr_en_off", mem_bus.mem_enable, 0);
        check("wr_busy_off", busy, 0);
        check("wr_fill_done", i_fill_done | d_fill_done, 0);
        step();
        d_wr_req = 1'b0;
        w_pend   = 1'b0;
    endtask

    task automatic serve();
        owner_t w;
        if (w_pend) begin
            exec_write(d_wr_addr, d_wr_data);
        end else if (i_pend && d_pend) begin
            w       = rr_next;
            rr_next = (w == OWN_I) ? OWN_D : OWN_I;
            exec_fill(w, (w == OWN_I) ? i_miss_addr : d_miss_addr);
        end else if (i_pend) begin
            exec_fill(OWN_I, i_miss_addr);
        end else if (d_pend) begin
            exec_fill(OWN_D, d_miss_addr);
        end
    endtask

    task automatic run_all();
        int guard = 0;
        while ((i_pend || d_pend || w_pend) && guard < 8) begin
            serve();
            guard++;
        end
        check("run_all_drained", {i_pend, d_pend, w_pend}, 0);
    endtask

    task automatic spur_idle(input string p);
        spur = 1'b1;
        step();
        sample();
        check({p, "_valid_seen"}, mem_bus.mem_data_valid, 1);
        check({p, "_iwe"}, i_fill_we, 0);
        check({p, "_dwe"}, d_fill_we, 0);
        check({p, "_idx"}, fill_word_idx, 0);
        check({p, "_busy"}, busy, 0);
        spur = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] m;
        mem_bus.mem_data_valid = 1'b0;
        mem_bus.mem_rdata      = '0;
        repeat (2) step();
        check_quiet("rst");
        rst_n = 1'b1;
        step();

        // Lone I miss, mid-block address.
        i_miss = 1'b1; i_miss_addr = 16'h1236; i_pend = 1'b1;
        run_all();

        // Tie after reset: I first, then D; second tie: D first.
        i_miss = 1'b1; i_miss_addr = 16'h0100; i_pend = 1'b1;
        d_miss = 1'b1; d_miss_addr = 16'h0A28; d_pend = 1'b1;
        run_all();
        i_miss = 1'b1; i_miss_addr = 16'h7772; i_pend = 1'b1;
        d_miss = 1'b1; d_miss_addr = 16'h9990; d_pend = 1'b1;
        run_all();

        // Store arriving mid-fill waits for the fill to finish.
        i_miss = 1'b1; i_miss_addr = 16'h0ABC; i_pend = 1'b1;
        inject_c = 3; inj_addr = 16'h4000; inj_data = 16'hBEEF;
        run_all();

        // D miss with a non-zero word offset.
        d_miss = 1'b1; d_miss_addr = 16'h200A; d_pend = 1'b1;
        run_all();

        spur_idle("spur0");

        for (int r = 0; r < 12; r++) begin
            m = 3'($urandom_range(1, 7));
            i_pend = m[0]; d_pend = m[1]; w_pend = m[2];
            i_miss_addr = 16'($urandom);
            d_miss_addr = 16'($urandom);
            d_wr_addr   = 16'($urandom);
            d_wr_data   = 16'($urandom);
            i_miss = i_pend; d_miss = d_pend; d_wr_req = w_pend;
            if (!w_pend && $urandom_range(0, 2) == 0) begin
                inject_c = $urandom_range(1, 12);
                inj_addr = 16'($urandom);
                inj_data = 16'($urandom);
            end
            drop_c = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : -1;
            run_all();
            drop_c = -1;
            if ($urandom_range(0, 1) == 1) spur_idle("spur_r");
        end

        // Reset after three returns of an I fill.
        i_miss = 1'b1; i_miss_addr = 16'h5A5E; i_pend = 1'b1;
        for (int c = 1; c <= 7; c++) step();
        sample();
        check("prerst_we", i_fill_we, 1);
        check("prerst_idx", fill_word_idx, 2);
        step();
        rst_n = 1'b0;
        i_miss = 1'b0; i_pend = 1'b0;
        #1;
        check_quiet("midrst");
        sample();
        check("midrst_we", i_fill_we, 0);
        step();
        step();
        rst_n = 1'b1;
        rr_next = OWN_I;
        for (int c = 0; c < 6; c++) begin
            sample();
            check($sformatf("late_we c%0d", c), i_fill_we | d_fill_we, 0);
            check($sformatf("late_done c%0d", c), i_fill_done | d_fill_done, 0);
            check($sformatf("late_busy c%0d", c), busy, 0);
            step();
        end

        // Pointer back to I after reset.
        i_miss = 1'b1; i_miss_addr = 16'h3210; i_pend = 1'b1;
        d_miss = 1'b1; d_miss_addr = 16'h4326; d_pend = 1'b1;
        run_all();
        sample();
        check("end_idle", mem_bus.mem_enable | busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
